// File: rtl/instr_encoder.sv
//============================================================================
// Module   : instr_encoder (with package mips_pkg)
// Purpose  : Encodes mnemonic + register/immediate fields into 32-bit MIPS
//            words and streams them into instruction memory through a
//            one-deep registered write port, one word per cycle.
// Config   : `define ENC_NOP_PAD_EN to insert one NOP after each BEQ/JUMP.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package mips_pkg;

   localparam int DATA_32_W = 32;

   // Mnemonics presented on the request port
   typedef enum logic [4:0] {
      NEM_ZERO  = 5'd0,
      NEM_ADD   = 5'd1,
      NEM_AND   = 5'd2,
      NEM_OR    = 5'd3,
      NEM_SLT   = 5'd4,
      NEM_SUB   = 5'd5,
      NEM_XOR   = 5'd6,
      NEM_SRA   = 5'd7,
      NEM_SRL   = 5'd8,
      NEM_SLL   = 5'd9,
      NEM_MULT  = 5'd10,
      NEM_ADDI  = 5'd11,
      NEM_ADDIU = 5'd12,
      NEM_BEQ   = 5'd13,
      NEM_LW    = 5'd14,
      NEM_SW    = 5'd15,
      NEM_ABS   = 5'd16,
      NEM_JUMP  = 5'd17
   } t_instr_pnmen;

   // Primary opcodes
   localparam logic [5:0] OP_ZERO  = 6'h00;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ABS   = 6'h1F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

module instr_encoder
   import mips_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [ADDR_W-1:0]    i_base_addr,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  t_instr_pnmen         i_in_nem,
   input  logic [4:0]           i_in_rs,
   input  logic [4:0]           i_in_rt,
   input  logic [4:0]           i_in_rd,
   input  logic [4:0]           i_in_shamt,
   input  logic [15:0]          i_in_imm,
   input  logic [25:0]          i_in_target,
   output logic                 o_wr_valid,
   input  logic                 i_wr_ready,
   output logic [ADDR_W-1:0]    o_wr_addr,
   output logic [DATA_32_W-1:0] o_wr_data,
   output logic                 o_full,
   output logic                 o_err,
   output logic [ADDR_W:0]      o_words
);

   localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_WORD_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PAD  = 2'd2,
      FULL = 2'd3
   } t_state;

   t_state                 r_state;
   t_state                 w_state_nxt;
   logic                   r_wr_valid;
   logic [ADDR_W-1:0]      r_wr_addr;
   logic [DATA_32_W-1:0]   r_wr_data;
   logic [ADDR_W:0]        r_words;
   logic                   r_err;
   logic                   r_pad_sent;

   logic [DATA_32_W-1:0]   w_enc;
   logic                   w_illegal;
   logic                   w_is_branch;
   logic                   w_hs;
   logic                   w_last;
   logic                   w_slot_free;
   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_pad_load;

   // A branch/jump diverts the FSM through PAD only when padding is built in
`ifdef ENC_NOP_PAD_EN
   assign w_is_branch = (i_in_nem == NEM_BEQ) || (i_in_nem == NEM_JUMP);
`else
   assign w_is_branch = 1'b0;
`endif

   assign w_hs        = r_wr_valid & i_wr_ready;
   assign w_last      = (r_wr_addr == c_LAST_ADDR);
   // Output slot can take a new word: empty or draining, and never refilled
   // behind the word that targets the last address (no wrap-around).
   assign w_slot_free = (~r_wr_valid | i_wr_ready) & ~(r_wr_valid & w_last);
   assign w_accept    = i_in_valid & w_in_ready;

   // Mnemonic to machine-word encoder; unknown codes yield a NOP and flag error
   always_comb begin
      w_enc     = '0;
      w_illegal = 1'b0;
      case (i_in_nem)
         NEM_ZERO:  w_enc = '0;
         NEM_ADD:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_ADD};
         NEM_AND:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_AND};
         NEM_OR:    w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_OR};
         NEM_SLT:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_SLT};
         NEM_SUB:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_SUB};
         NEM_XOR:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_XOR};
         NEM_SRA:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_SRA};
         NEM_SRL:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_SRL};
         // An all-zero SLL naturally encodes to 32'h0, the canonical NOP
         NEM_SLL:   w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_SLL};
         NEM_MULT:  w_enc = {OP_ZERO, i_in_rs, i_in_rt, i_in_rd, i_in_shamt, FN_MULT};
         NEM_ADDI:  w_enc = {OP_ADDI,  i_in_rs, i_in_rt, i_in_imm};
         NEM_ADDIU: w_enc = {OP_ADDIU, i_in_rs, i_in_rt, i_in_imm};
         NEM_BEQ:   w_enc = {OP_BEQ,   i_in_rs, i_in_rt, i_in_imm};
         NEM_LW:    w_enc = {OP_LW,    i_in_rs, i_in_rt, i_in_imm};
         NEM_SW:    w_enc = {OP_SW,    i_in_rs, i_in_rt, i_in_imm};
         NEM_ABS:   w_enc = {OP_ABS,   i_in_rs, i_in_rt, 16'h0000};
         NEM_JUMP:  w_enc = {OP_JUMP,  i_in_target};
         default:   w_illegal = 1'b1;
      endcase
   end

   // Next-state and handshake decode; start overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_pad_load  = 1'b0;
      case (r_state)
         RUN: begin
            w_in_ready = ~i_start & w_slot_free;
            if (w_hs && w_last) begin
               w_state_nxt = FULL;
            end else if (i_in_valid && w_in_ready && w_is_branch) begin
               w_state_nxt = PAD;
            end
         end
         PAD: begin
            w_pad_load = ~i_start & ~r_pad_sent & w_slot_free;
            if (w_hs && w_last) begin
               w_state_nxt = FULL;
            end else if (w_hs && r_pad_sent) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
      if (i_start) begin
         w_state_nxt = RUN;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output word register, address/word counters and sticky error
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_words    <= '0;
         r_err      <= 1'b0;
         r_pad_sent <= 1'b0;
      end else if (i_start) begin
         r_wr_valid <= 1'b0;
         r_wr_addr  <= i_base_addr;
         r_wr_data  <= '0;
         r_words    <= '0;
         r_err      <= 1'b0;
         r_pad_sent <= 1'b0;
      end else begin
         if (w_hs) begin
            r_wr_valid <= 1'b0;
            r_words    <= r_words + c_WORD_ONE;
            if (!w_last) begin
               r_wr_addr <= r_wr_addr + c_ADDR_ONE;
            end
            // Pad word drained (or memory filled): padding round complete
            if (r_pad_sent || w_last) begin
               r_pad_sent <= 1'b0;
            end
         end
         if (w_accept) begin
            r_wr_valid <= 1'b1;
            r_wr_data  <= w_enc;
            if (w_illegal) begin
               r_err <= 1'b1;
            end
         end
         if (w_pad_load) begin
            r_wr_valid <= 1'b1;
            r_wr_data  <= '0;
            r_pad_sent <= 1'b1;
         end
      end
   end

   assign o_in_ready = w_in_ready;
   assign o_wr_valid = r_wr_valid;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_full     = (r_state == FULL);
   assign o_err      = r_err;
   assign o_words    = r_words;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed, table-driven bench for instr_encoder.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instr_encoder;
   import mips_pkg::*;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [AW-1:0]     base_addr;
   logic              in_valid;
   logic              in_ready;
   t_instr_pnmen      in_nem;
   logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              wr_valid;
   logic              wr_ready;
   logic [AW-1:0]     wr_addr;
   logic [31:0]       wr_data;
   logic              full;
   logic              err;
   logic [AW:0]       words;

   int n_tests = 0;
   int n_fail  = 0;

   instr_encoder #(.IMEM_DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_nem    (in_nem),
      .i_in_rs     (in_rs),
      .i_in_rt     (in_rt),
      .i_in_rd     (in_rd),
      .i_in_shamt  (in_shamt),
      .i_in_imm    (in_imm),
      .i_in_target (in_target),
      .o_wr_valid  (wr_valid),
      .i_wr_ready  (wr_ready),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_full      (full),
      .o_err       (err),
      .o_words     (words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      t_instr_pnmen nem;
      logic [4:0]   rs;
      logic [4:0]   rt;
      logic [4:0]   rd;
      logic [4:0]   sh;
      logic [15:0]  imm;
      logic [25:0]  tgt;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one request and wait (bounded) for acceptance; returns at the
   // falling edge after the accepting rising edge.
   task automatic send(input t_instr_pnmen nem, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input int max_cyc, output bit ok);
      in_nem = nem; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_imm = imm; in_target = tgt; in_valid = 1'b1; ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         #1;
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic req(input string name, input t_instr_pnmen nem, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt);
      bit ok;
      send(nem, rs, rt, rd, sh, imm, tgt, 20, ok);
      chk({name, "_accepted"}, 64'(ok), 64'd1);
   endtask

   task automatic do_start(input logic [AW-1:0] b);
      start = 1'b1; base_addr = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      bit ok;
      vecs[0]  = '{NEM_ADD,   5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0, 32'h00221820};
      vecs[1]  = '{NEM_AND,   5'd3,  5'd4,  5'd5,  5'd0,  16'h0,    26'h0, 32'h00642824};
      vecs[2]  = '{NEM_OR,    5'd31, 5'd0,  5'd1,  5'd0,  16'h0,    26'h0, 32'h03E00825};
      vecs[3]  = '{NEM_SLT,   5'd2,  5'd3,  5'd4,  5'd0,  16'h0,    26'h0, 32'h0043202A};
      vecs[4]  = '{NEM_SUB,   5'd5,  5'd6,  5'd7,  5'd0,  16'h0,    26'h0, 32'h00A63822};
      vecs[5]  = '{NEM_XOR,   5'd8,  5'd9,  5'd10, 5'd0,  16'h0,    26'h0, 32'h01095026};
      vecs[6]  = '{NEM_SRA,   5'd0,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0, 32'h000110C3};
      vecs[7]  = '{NEM_SRL,   5'd0,  5'd4,  5'd4,  5'd31, 16'h0,    26'h0, 32'h000427C2};
      vecs[8]  = '{NEM_SLL,   5'd0,  5'd2,  5'd3,  5'd4,  16'h0,    26'h0, 32'h00021900};
      vecs[9]  = '{NEM_SLL,   5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0, 32'h00000000};
      vecs[10] = '{NEM_MULT,  5'd1,  5'd2,  5'd0,  5'd0,  16'h0,    26'h0, 32'h00220018};
      vecs[11] = '{NEM_ADDI,  5'd1,  5'd2,  5'd0,  5'd0,  16'h1234, 26'h0, 32'h20221234};
      vecs[12] = '{NEM_ADDIU, 5'd3,  5'd4,  5'd0,  5'd0,  16'hFFFF, 26'h0, 32'h2464FFFF};
      vecs[13] = '{NEM_LW,    5'd4,  5'd5,  5'd0,  5'd0,  16'h0010, 26'h0, 32'h8C850010};
      vecs[14] = '{NEM_SW,    5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 26'h0, 32'hAFBF0008};
      vecs[15] = '{NEM_ABS,   5'd6,  5'd7,  5'd0,  5'd0,  16'hBEEF, 26'h0, 32'h7CC70000};
      vecs[16] = '{NEM_ZERO,  5'd9,  5'd9,  5'd9,  5'd9,  16'h1111, 26'h5, 32'h00000000};

      rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; wr_ready = 1'b1;
      in_nem = NEM_ZERO; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_imm = '0; in_target = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_wr_addr",  64'(wr_addr),  64'd0);
      chk("rst_wr_data",  64'(wr_data),  64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_full",     64'(full),     64'd0);
      chk("rst_err",      64'(err),      64'd0);
      chk("rst_words",    64'(words),    64'd0);

      // No acceptance before start
      rst_n = 1'b1;
      in_valid = 1'b1; in_nem = NEM_ADD;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_in_ready", 64'(in_ready), 64'd0);
         chk("idle_wr_valid", 64'(wr_valid), 64'd0);
      end
      in_valid = 1'b0;

      // ADD scenario
      do_start(6'd0);
      chk("start_addr", 64'(wr_addr), 64'd0);
      req("add", NEM_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      chk("add_valid", 64'(wr_valid), 64'd1);
      chk("add_addr",  64'(wr_addr),  64'd0);
      chk("add_data",  64'(wr_data),  64'h00221820);
      @(negedge clk);
      chk("add_words", 64'(words), 64'd1);

      // Table: back-to-back encodings, one per cycle from base 8
      do_start(6'd8);
      for (int i = 0; i < 17; i++) begin
         req($sformatf("vec%0d", i), vecs[i].nem, vecs[i].rs, vecs[i].rt, vecs[i].rd,
             vecs[i].sh, vecs[i].imm, vecs[i].tgt);
         chk($sformatf("vec%0d_data", i),  64'(wr_data),  64'(vecs[i].exp));
         chk($sformatf("vec%0d_addr", i),  64'(wr_addr),  64'(8 + i));
         chk($sformatf("vec%0d_words", i), 64'(words),    64'(i));
      end
      @(negedge clk);
      chk("tbl_final_words", 64'(words), 64'd17);
      chk("tbl_final_valid", 64'(wr_valid), 64'd0);

      // Back-pressure: LW held for 3 cycles
      do_start(6'd20);
      wr_ready = 1'b0;
      req("lw", NEM_LW, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0);
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid",    64'(wr_valid), 64'd1);
         chk("bp_data",     64'(wr_data),  64'h8C850010);
         chk("bp_addr",     64'(wr_addr),  64'd20);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      wr_ready = 1'b1;
      @(negedge clk);
      chk("bp_done_valid", 64'(wr_valid), 64'd0);
      chk("bp_done_words", 64'(words),    64'd1);
      chk("bp_done_addr",  64'(wr_addr),  64'd21);

      // Branch / jump sequence
      do_start(6'd0);
      req("beq", NEM_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
      chk("beq_data", 64'(wr_data), 64'h1022FFFF);
      chk("beq_addr", 64'(wr_addr), 64'd0);
`ifdef ENC_NOP_PAD_EN
      @(negedge clk);
      chk("pad_valid",    64'(wr_valid), 64'd1);
      chk("pad_data",     64'(wr_data),  64'd0);
      chk("pad_addr",     64'(wr_addr),  64'd1);
      chk("pad_in_ready", 64'(in_ready), 64'd0);
      req("addi", NEM_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0);
      chk("addi_addr", 64'(wr_addr), 64'd2);
      chk("addi_data", 64'(wr_data), 64'h20221234);
      @(negedge clk);
      chk("br_words", 64'(words), 64'd3);
      req("jump", NEM_JUMP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1234567);
      chk("jump_data", 64'(wr_data), 64'h09234567);
      chk("jump_addr", 64'(wr_addr), 64'd3);
      @(negedge clk);
      chk("jpad_data", 64'(wr_data), 64'd0);
      chk("jpad_addr", 64'(wr_addr), 64'd4);
      @(negedge clk);
      chk("jpad_words", 64'(words), 64'd5);
`else
      req("addi", NEM_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0);
      chk("addi_addr", 64'(wr_addr), 64'd1);
      chk("addi_data", 64'(wr_data), 64'h20221234);
      req("jump", NEM_JUMP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1234567);
      chk("jump_data", 64'(wr_data), 64'h09234567);
      chk("jump_addr", 64'(wr_addr), 64'd2);
      @(negedge clk);
      chk("br_words", 64'(words), 64'd3);
`endif

      // Full: two writes land at DEPTH-2 and DEPTH-1, third is refused
      do_start(6'(DEPTH - 2));
      req("full1", NEM_ADD, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
      chk("full1_addr", 64'(wr_addr), 64'(DEPTH - 2));
      req("full2", NEM_SUB, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0);
      chk("full2_addr", 64'(wr_addr), 64'(DEPTH - 1));
      send(NEM_OR, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0, 26'h0, 4, ok);
      chk("full3_refused", 64'(ok),      64'd0);
      chk("full_flag",     64'(full),    64'd1);
      chk("full_valid",    64'(wr_valid), 64'd0);
      chk("full_words",    64'(words),   64'd2);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_addr",     64'(wr_addr), 64'(DEPTH - 1));

      // Reset mid-transfer, then illegal mnemonic
      do_start(6'd3);
      wr_ready = 1'b0;
      req("pre_rst", NEM_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 64'(wr_valid), 64'd0);
      chk("mrst_addr",  64'(wr_addr),  64'd0);
      chk("mrst_data",  64'(wr_data),  64'd0);
      chk("mrst_words", 64'(words),    64'd0);
      @(negedge clk);
      rst_n = 1'b1; wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_after_words", 64'(words), 64'd0);
      do_start(6'd0);
      req("illegal", t_instr_pnmen'(5'd30), 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h3FFFFFF);
      chk("illegal_data",  64'(wr_data),  64'd0);
      chk("illegal_valid", 64'(wr_valid), 64'd1);
      chk("illegal_err",   64'(err),      64'd1);
      req("post_illegal", NEM_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      chk("err_sticky", 64'(err), 64'd1);

      // Start-abort while a word is stalled
      do_start(6'd5);
      chk("start_clears_err", 64'(err), 64'd0);
      wr_ready = 1'b0;
      req("abort_sub", NEM_SUB, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
      chk("abort_pending", 64'(wr_valid), 64'd1);
      start = 1'b1; base_addr = 6'd40;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("abort_valid", 64'(wr_valid), 64'd0);
      chk("abort_addr",  64'(wr_addr),  64'd40);
      chk("abort_words", 64'(words),    64'd0);
      wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_write", 64'(words), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, meaning the instruction-memory size in 32-bit words; it SHALL be a power of two, at least 4.
REQ-002 Parameter ADDR_W, default $clog2(IMEM_DEPTH), meaning the word-address width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, SHALL be asynchronous and active-low.
REQ-005 start  in  1  SHALL load base_addr and begin a new program.
REQ-006 base_addr  in  ADDR_W  SHALL give the first write address.
REQ-007 in_valid / in_ready  in / out  1 / 1  SHALL form the instruction-request handshake.
REQ-008 in_nem  in  t_instr_pnmen  SHALL carry the mnemonic to encode.
REQ-009 in_rs, in_rt, in_rd, in_shamt  in  5 each  SHALL carry the register and shift fields.
REQ-010 in_imm  in  16 / in_target  in  26  SHALL carry the I-type immediate and the J-type target.
REQ-011 wr_valid / wr_ready  out / in  1 / 1  SHALL form the instruction-memory write handshake.
REQ-012 wr_addr  out  ADDR_W / wr_data  out  DATA_32_W  SHALL carry the write word address and the encoded instruction.
REQ-013 full  out  1  SHALL be high when the last address has been written.
REQ-014 err  out  1  SHALL be a sticky flag for an illegal mnemonic.
REQ-015 words  out  ADDR_W+1  SHALL count the words written since start.

Function
REQ-016 Encoding SHALL use the mips_pkg opcode/funct constants, so the decode stage recovers the same mnemonic:
- R-type (ADD, AND, OR, SLT, SUB, XOR, SRA, SRL, SLL, MULT): {ZERO, rs, rt, rd, shamt, funct}.
- ADDI, ADDIU, BEQ, LW, SW: {op, rs, rt, imm}.
- ABS: {ABS, rs, rt, imm} with imm = 0.
- JUMP: {JUMP, target}.
- NEM_ZERO: 32'h0 (NOP).
REQ-017 An SLL whose fields are all zero SHALL encode as 32'h0 and count as a NOP.
REQ-018 FSM states SHALL be IDLE, RUN, PAD, FULL; reset state is IDLE.
REQ-019 Transitions:
- Any state -> RUN on start.
- RUN -> PAD after accepting a BEQ or JUMP (macro on).
- PAD -> RUN when the pad NOP is accepted by the write port.
- RUN/PAD -> FULL on the write handshake at address IMEM_DEPTH-1.
- FULL holds until start.
REQ-020 in_ready SHALL be 1 only in RUN, with start low, and with the output register empty or draining that cycle (wr_ready high).
REQ-021 Latency SHALL be one cycle: a request accepted at edge N presents wr_valid with the encoded word after edge N.
REQ-022 wr_valid, wr_addr and wr_data SHALL stay stable until wr_ready is high.
REQ-023 Back-to-back: with wr_ready held high, one word SHALL be written per cycle with no bubble.
REQ-024 wr_addr SHALL increment by 1 on each write handshake; words SHALL increment by 1 on each write handshake.
REQ-025 No wrap-around: after the write at IMEM_DEPTH-1, full=1, wr_valid=0, in_ready=0.
REQ-026 start SHALL have priority over all events:
- discard any pending output word (wr_valid falls next cycle);
- load wr_addr = base_addr;
- clear words, full and err.
REQ-027 A request accepted with an out-of-range in_nem SHALL write a NOP and set err.

Reset
REQ-028 While rst=0: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, in_ready=0, full=0, err=0, words=0.
REQ-029 Reset asserted mid-transfer SHALL drop the pending word with no write completed.
REQ-030 After rst rises, no request SHALL be accepted until start.

Configuration
REQ-031 Macro ENC_NOP_PAD_EN:
- Defined: after each BEQ or JUMP, the encoder SHALL emit one 32'h0 at the next address via PAD, with in_ready=0 in PAD.
- Undefined: PAD SHALL be unreachable and no padding inserted.

Verification
REQ-032 ADD scenario: start, base_addr=0; ADD rs=1 rt=2 rd=3 -> wr_addr=0, wr_data=32'h00221820 one cycle after acceptance.
REQ-033 Back-pressure scenario: hold wr_ready=0 for 3 cycles during LW rs=4 rt=5 imm=16'h0010 -> wr_data=32'h8C850010 held stable and in_ready=0 until the handshake.
REQ-034 Branch padding scenario (macro on): BEQ rs=1 rt=2 imm=16'hFFFF then ADDI -> words at addresses 0, 1, 2 are 32'h1022FFFF, 32'h0, then the ADDI; words=3.
REQ-035 Full scenario: base_addr=IMEM_DEPTH-2, send 3 requests -> 2 writes, full=1, third request not accepted.
REQ-036 Start-abort scenario: start asserted while wr_valid=1 and wr_ready=0 -> word discarded, wr_addr=base_addr, words=0.
REQ-037 Reset and illegal-mnemonic scenario: reset asserted mid-run -> all outputs zero; after start, an illegal in_nem -> wr_data=0, err=1.
